multicycle_ctrl: RTL and testbench

Parametrised multicycle control FSM for the MIPS core, successor to the fixed five-state sequencer. Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, adds ready/valid handshakes to instruction and data memory, and stalls EXEC for a parametrised number of cycles on multiply. It also flags illegal opcodes and counts retired instructions. It sits between the fetch unit, the datapath stage registers and the memory ports, and drives one-hot stage enables.

---
 rtl/multicycle_ctrl.sv | 127 ++++++++++++
 tb/tb_multicycle_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with memory
// handshakes, multi-cycle multiply stall, illegal-opcode flag and retire counter.
module multicycle_ctrl #(
  parameter int unsigned MUL_LAT = 4,
  parameter bit          MUL_EN  = 1'b1,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             imem_valid,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             execute_en,
  output logic             memory_en,
  output logic             writeback_en,
  output logic             wb_sel,
  output logic             retire,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_cnt
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_MULT  = 6'b011000;

  state_t      state, nxt;
  logic [31:0] ir;
  logic [3:0]  exec_cnt;
  logic [5:0]  op, funct;
  logic        is_nop, is_j, is_mult, is_branch, is_lw, is_sw, known, is_illegal, is_skip;

  assign op    = ir[31:26];
  assign funct = ir[5:0];

  always_comb begin
    is_nop    = (ir == '0);
    is_j      = (op == OP_J);
    is_mult   = (op == OP_RTYPE) && !is_nop && (funct == FN_MULT);
    is_branch = (op == OP_BEQ) || (op == OP_BNE);
    is_lw     = (op == OP_LW);
    is_sw     = (op == OP_SW);
    case (op)
      OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI,
      OP_ORI, OP_LUI, OP_LW, OP_SW: known = 1'b1;
      default:                      known = 1'b0;
    endcase
    is_illegal = !known || (is_mult && !MUL_EN);
    is_skip    = is_nop || is_j || is_illegal;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_FETCH:  if (imem_valid) nxt = S_DECODE;
      S_DECODE: nxt = is_skip ? S_FETCH : S_EXEC;
      S_EXEC: begin
        if (exec_cnt == '0) begin
          if (is_branch)          nxt = S_FETCH;
          else if (is_lw || is_sw) nxt = S_MEM;
          else                    nxt = S_WB;
        end
      end
      S_MEM:    if (dmem_ready) nxt = is_sw ? S_FETCH : S_WB;
      S_WB:     nxt = S_FETCH;
      default:  nxt = S_FETCH;
    endcase
  end

  // Retire marks the exit cycle of whichever state ends the instruction.
  assign retire = ((state == S_DECODE) && (is_nop || is_j))
                || ((state == S_EXEC) && (exec_cnt == '0) && is_branch)
                || ((state == S_MEM) && dmem_ready && is_sw)
                || (state == S_WB);
  assign illegal = (state == S_DECODE) && is_illegal;

  // Stage enables and memory strobes are registered from the next state so they
  // switch together with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_FETCH;
      ir           <= '0;
      exec_cnt     <= '0;
      fetch_en     <= 1'b1;
      decode_en    <= 1'b0;
      execute_en   <= 1'b0;
      memory_en    <= 1'b0;
      writeback_en <= 1'b0;
      imem_req     <= 1'b1;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      wb_sel       <= 1'b0;
      retired_cnt  <= '0;
    end else begin
      state        <= nxt;
      fetch_en     <= (nxt == S_FETCH);
      decode_en    <= (nxt == S_DECODE);
      execute_en   <= (nxt == S_EXEC);
      memory_en    <= (nxt == S_MEM);
      writeback_en <= (nxt == S_WB);
      imem_req     <= (nxt == S_FETCH);
      dmem_req     <= (nxt == S_MEM);
      dmem_we      <= (nxt == S_MEM) && is_sw;
      if (nxt == S_WB) wb_sel <= is_lw;
      if ((state == S_FETCH) && imem_valid) ir <= instr;
      if (state == S_DECODE)
        exec_cnt <= is_mult ? 4'(MUL_LAT - 1) : '0;
      else if ((state == S_EXEC) && (exec_cnt != '0))
        exec_cnt <= exec_cnt - 4'd1;
      if (retire) retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle expected stage/strobe
// vectors are queued with their stimulus and compared at the falling edge.
module tb_multicycle_ctrl;

  localparam logic [4:0]  F = 5'b00001, D = 5'b00010, E = 5'b00100, M = 5'b01000, W = 5'b10000;
  localparam logic [31:0] ADDI = 32'h2001_0005, LW = 32'h8C01_0000, SW = 32'hAC01_0000;
  localparam logic [31:0] MULT = 32'h0022_0018, BNE = 32'h1422_0003, JMP = 32'h0800_0010;
  localparam logic [31:0] BAD  = 32'hFC00_0000, JUNK = 32'hDEAD_BEEF, NOP = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic        vld;
    logic        rdy;
    logic [4:0]  en;
    logic        ret;
    logic        ill;
    logic        dwe;
    logic        wbs;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr = '0;
  logic        imem_valid = 1'b0;
  logic        dmem_ready = 1'b0;

  logic imem_req_m, dmem_req_m, dmem_we_m, f_m, d_m, e_m, mm_m, w_m, wb_sel_m, retire_m, illegal_m;
  logic imem_req_n, dmem_req_n, dmem_we_n, f_n, d_n, e_n, mm_n, w_n, wb_sel_n, retire_n, illegal_n;
  logic imem_req_c, dmem_req_c, dmem_we_c, f_c, d_c, e_c, mm_c, w_c, wb_sel_c, retire_c, illegal_c;
  logic [31:0] cnt_m, cnt_n;
  logic [3:0]  cnt_c;
  logic [10:0] obs_m, obs_n, obs_c;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MUL_LAT(4), .MUL_EN(1'b1), .CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .instr(instr), .imem_valid(imem_valid), .dmem_ready(dmem_ready),
    .imem_req(imem_req_m), .dmem_req(dmem_req_m), .dmem_we(dmem_we_m),
    .fetch_en(f_m), .decode_en(d_m), .execute_en(e_m), .memory_en(mm_m), .writeback_en(w_m),
    .wb_sel(wb_sel_m), .retire(retire_m), .illegal(illegal_m), .retired_cnt(cnt_m));

  multicycle_ctrl #(.MUL_LAT(4), .MUL_EN(1'b0), .CNT_W(32)) u_nomul (
    .clk(clk), .reset(reset), .instr(instr), .imem_valid(imem_valid), .dmem_ready(dmem_ready),
    .imem_req(imem_req_n), .dmem_req(dmem_req_n), .dmem_we(dmem_we_n),
    .fetch_en(f_n), .decode_en(d_n), .execute_en(e_n), .memory_en(mm_n), .writeback_en(w_n),
    .wb_sel(wb_sel_n), .retire(retire_n), .illegal(illegal_n), .retired_cnt(cnt_n));

  multicycle_ctrl #(.MUL_LAT(4), .MUL_EN(1'b1), .CNT_W(4)) u_cnt4 (
    .clk(clk), .reset(reset), .instr(instr), .imem_valid(imem_valid), .dmem_ready(dmem_ready),
    .imem_req(imem_req_c), .dmem_req(dmem_req_c), .dmem_we(dmem_we_c),
    .fetch_en(f_c), .decode_en(d_c), .execute_en(e_c), .memory_en(mm_c), .writeback_en(w_c),
    .wb_sel(wb_sel_c), .retire(retire_c), .illegal(illegal_c), .retired_cnt(cnt_c));

  assign obs_m = {w_m, mm_m, e_m, d_m, f_m, retire_m, illegal_m, dmem_we_m, dmem_req_m, imem_req_m, wb_sel_m};
  assign obs_n = {w_n, mm_n, e_n, d_n, f_n, retire_n, illegal_n, dmem_we_n, dmem_req_n, imem_req_n, wb_sel_n};
  assign obs_c = {w_c, mm_c, e_c, d_c, f_c, retire_c, illegal_c, dmem_we_c, dmem_req_c, imem_req_c, wb_sel_c};

  function automatic exp_t mk(input logic [31:0] i, input logic v, input logic r, input logic [4:0] en,
                              input logic ret, input logic ill, input logic dwe, input logic wbs);
    exp_t e;
    e.instr = i; e.vld = v; e.rdy = r; e.en = en;
    e.ret = ret; e.ill = ill; e.dwe = dwe; e.wbs = wbs;
    return e;
  endfunction

  // dmem_req follows the MEM enable and imem_req the FETCH enable.
  function automatic logic [10:0] expv(input exp_t e);
    return {e.en, e.ret, e.ill, e.dwe, e.en[3], e.en[0], e.wbs};
  endfunction

  task automatic reset_dut();
    reset = 1'b1; imem_valid = 1'b0; dmem_ready = 1'b0; instr = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [10:0] rv;
    rv = expv(mk(NOP, 1'b0, 1'b0, F, 1'b0, 1'b0, 1'b0, 1'b0));
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs_m !== rv) $display("FAIL reset_outputs: got %b expected %b", obs_m, rv);
    else passed++;
    checks++;
    if (cnt_m !== 32'd0) $display("FAIL reset_count: got %0d expected 0", cnt_m);
    else passed++;
  endtask

  task automatic test_addi();
    exp_t q[$];
    exp_t e;
    int cyc = 1;
    reset_dut();
    q.push_back(mk(ADDI, 1, 1, F, 0, 0, 0, 0));
    q.push_back(mk(JUNK, 1, 1, D, 0, 0, 0, 0));
    q.push_back(mk(JUNK, 1, 1, E, 0, 0, 0, 0));
    q.push_back(mk(JUNK, 1, 1, W, 1, 0, 0, 0));
    while (q.size() != 0) begin
      e = q.pop_front();
      instr = e.instr; imem_valid = e.vld; dmem_ready = e.rdy;
      @(negedge clk);
      checks++;
      if (obs_m !== expv(e)) $display("FAIL addi cyc%0d: got %b expected %b", cyc, obs_m, expv(e));
      else passed++;
      cyc++;
      @(posedge clk); #1;
    end
    imem_valid = 1'b0;
    checks++;
    if (cnt_m !== 32'd1) $display("FAIL addi_count: got %0d expected 1", cnt_m);
    else passed++;
  endtask

  task automatic test_lw_stall();
    exp_t q[$];
    exp_t e;
    int cyc = 1;
    reset_dut();
    q.push_back(mk(LW,   1, 0, F, 0, 0, 0, 0));
    q.push_back(mk(JUNK, 1, 0, D, 0, 0, 0, 0));
    q.push_back(mk(JUNK, 1, 0, E, 0, 0, 0, 0));
    q.push_back(mk(JUNK, 1, 0, M, 0, 0, 0, 0));
    q.push_back(mk(JUNK, 1, 0, M, 0, 0, 0, 0));
    q.push_back(mk(JUNK, 1, 1, M, 0, 0, 0, 0));
    q.push_back(mk(JUNK, 1, 0, W, 1, 0, 0, 1));
    q.push_back(mk(JUNK, 0, 0, F, 0, 0, 0, 1));
    while (q.size() != 0) begin
      e = q.pop_front();
      instr = e.instr; imem_valid = e.vld; dmem_ready = e.rdy;
      @(negedge clk);
      checks++;
      if (obs_m !== expv(e)) $display("FAIL lw cyc%0d: got %b expected %b", cyc, obs_m, expv(e));
      else passed++;
      cyc++;
      @(posedge clk); #1;
    end
    checks++;
    if (cnt_m !== 32'd1) $display("FAIL lw_count: got %0d expected 1", cnt_m);
    else passed++;
  endtask

  task automatic test_sw();
    exp_t q[$];
    exp_t e;
    int cyc = 1;
    reset_dut();
    q.push_back(mk(SW,   1, 1, F, 0, 0, 0, 0));
    q.push_back(mk(JUNK, 1, 1, D, 0, 0, 0, 0));
    q.push_back(mk(JUNK, 1, 1, E, 0, 0, 0, 0));
    q.push_back(mk(JUNK, 1, 0, M, 0, 0, 1, 0));
    q.push_back(mk(JUNK, 1, 1, M, 1, 0, 1, 0));
    q.push_back(mk(JUNK, 0, 1, F, 0, 0, 0, 0));
    while (q.size() != 0) begin
      e = q.pop_front();
      instr = e.instr; imem_valid = e.vld; dmem_ready = e.rdy;
      @(negedge clk);
      checks++;
      if (obs_m !== expv(e)) $display("FAIL sw cyc%0d: got %b expected %b", cyc, obs_m, expv(e));
      else passed++;
      cyc++;
      @(posedge clk); #1;
    end
    checks++;
    if (cnt_m !== 32'd1) $display("FAIL sw_count: got %0d expected 1", cnt_m);
    else passed++;
  endtask

  task automatic test_mult();
    exp_t q[$];
    exp_t e;
    int cyc = 1;
    reset_dut();
    q.push_back(mk(MULT, 1, 1, F, 0, 0, 0, 0));
    q.push_back(mk(JUNK, 1, 1, D, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) q.push_back(mk(JUNK, 1, 1, E, 0, 0, 0, 0));
    q.push_back(mk(JUNK, 1, 1, W, 1, 0, 0, 0));
    q.push_back(mk(JUNK, 0, 1, F, 0, 0, 0, 0));
    while (q.size() != 0) begin
      e = q.pop_front();
      instr = e.instr; imem_valid = e.vld; dmem_ready = e.rdy;
      @(negedge clk);
      checks++;
      if (obs_m !== expv(e)) $display("FAIL mult cyc%0d: got %b expected %b", cyc, obs_m, expv(e));
      else passed++;
      cyc++;
      @(posedge clk); #1;
    end
    checks++;
    if (cnt_m !== 32'd1) $display("FAIL mult_count: got %0d expected 1", cnt_m);
    else passed++;

    // Same word on the multiply-less build: retire one ADDI, then MULT traps.
    reset_dut();
    cyc = 1;
    q.push_back(mk(ADDI, 1, 1, F, 0, 0, 0, 0));
    q.push_back(mk(JUNK, 1, 1, D, 0, 0, 0, 0));
    q.push_back(mk(JUNK, 1, 1, E, 0, 0, 0, 0));
    q.push_back(mk(JUNK, 1, 1, W, 1, 0, 0, 0));
    q.push_back(mk(MULT, 1, 1, F, 0, 0, 0, 0));
    q.push_back(mk(JUNK, 0, 1, D, 0, 1, 0, 0));
    q.push_back(mk(JUNK, 0, 1, F, 0, 0, 0, 0));
    while (q.size() != 0) begin
      e = q.pop_front();
      instr = e.instr; imem_valid = e.vld; dmem_ready = e.rdy;
      @(negedge clk);
      checks++;
      if (obs_n !== expv(e)) $display("FAIL nomul cyc%0d: got %b expected %b", cyc, obs_n, expv(e));
      else passed++;
      cyc++;
      @(posedge clk); #1;
    end
    checks++;
    if (cnt_n !== 32'd1) $display("FAIL nomul_count: got %0d expected 1", cnt_n);
    else passed++;
  endtask

  task automatic test_back_to_back();
    exp_t q[$];
    exp_t e;
    int cyc = 1;
    reset_dut();
    q.push_back(mk(BAD,  1, 1, F, 0, 0, 0, 0));
    q.push_back(mk(JUNK, 1, 1, D, 0, 1, 0, 0));
    q.push_back(mk(BNE,  1, 1, F, 0, 0, 0, 0));
    q.push_back(mk(JUNK, 1, 1, D, 0, 0, 0, 0));
    q.push_back(mk(JUNK, 1, 1, E, 1, 0, 0, 0));
    q.push_back(mk(JMP,  1, 1, F, 0, 0, 0, 0));
    q.push_back(mk(JUNK, 1, 1, D, 1, 0, 0, 0));
    q.push_back(mk(NOP,  1, 1, F, 0, 0, 0, 0));
    q.push_back(mk(JUNK, 1, 1, D, 1, 0, 0, 0));
    q.push_back(mk(JUNK, 0, 1, F, 0, 0, 0, 0));
    while (q.size() != 0) begin
      e = q.pop_front();
      instr = e.instr; imem_valid = e.vld; dmem_ready = e.rdy;
      @(negedge clk);
      checks++;
      if (obs_m !== expv(e)) $display("FAIL b2b cyc%0d: got %b expected %b", cyc, obs_m, expv(e));
      else passed++;
      cyc++;
      @(posedge clk); #1;
    end
    checks++;
    if (cnt_m !== 32'd3) $display("FAIL b2b_count: got %0d expected 3", cnt_m);
    else passed++;
  endtask

  task automatic test_cnt_wrap();
    exp_t q[$];
    exp_t e;
    int cyc = 1;
    reset_dut();
    for (int i = 0; i < 17; i++) begin
      q.push_back(mk(NOP, 1, 1, F, 0, 0, 0, 0));
      q.push_back(mk(NOP, 1, 1, D, 1, 0, 0, 0));
    end
    while (q.size() != 0) begin
      e = q.pop_front();
      instr = e.instr; imem_valid = e.vld; dmem_ready = e.rdy;
      @(negedge clk);
      checks++;
      if ({obs_m, obs_n, obs_c} !== {3{expv(e)}})
        $display("FAIL nop_run cyc%0d: got %b/%b/%b expected %b", cyc, obs_m, obs_n, obs_c, expv(e));
      else passed++;
      cyc++;
      @(posedge clk); #1;
    end
    imem_valid = 1'b0;
    checks++;
    if (cnt_c !== 4'd1) $display("FAIL cnt4_wrap: got %0d expected 1", cnt_c);
    else passed++;
    checks++;
    if (cnt_m !== 32'd17 || cnt_n !== 32'd17)
      $display("FAIL cnt32_nops: got %0d/%0d expected 17", cnt_m, cnt_n);
    else passed++;
  endtask

  task automatic test_reset_mid_mem();
    exp_t q[$];
    exp_t e;
    int cyc = 1;
    logic [10:0] mv, rv;
    reset_dut();
    q.push_back(mk(NOP,  1, 0, F, 0, 0, 0, 0));
    q.push_back(mk(JUNK, 1, 0, D, 1, 0, 0, 0));
    q.push_back(mk(LW,   1, 0, F, 0, 0, 0, 0));
    q.push_back(mk(JUNK, 1, 0, D, 0, 0, 0, 0));
    q.push_back(mk(JUNK, 1, 0, E, 0, 0, 0, 0));
    while (q.size() != 0) begin
      e = q.pop_front();
      instr = e.instr; imem_valid = e.vld; dmem_ready = e.rdy;
      @(negedge clk);
      checks++;
      if (obs_m !== expv(e)) $display("FAIL rstmem cyc%0d: got %b expected %b", cyc, obs_m, expv(e));
      else passed++;
      cyc++;
      @(posedge clk); #1;
    end
    mv = expv(mk(JUNK, 1, 0, M, 0, 0, 0, 0));
    rv = expv(mk(JUNK, 1, 0, F, 0, 0, 0, 0));
    @(negedge clk);
    checks++;
    if (obs_m !== mv || cnt_m !== 32'd1)
      $display("FAIL rstmem_in_mem: got %b cnt %0d expected %b cnt 1", obs_m, cnt_m, mv);
    else passed++;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs_m !== rv || cnt_m !== 32'd0)
      $display("FAIL rstmem_async: got %b cnt %0d expected %b cnt 0", obs_m, cnt_m, rv);
    else passed++;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_lw_stall();
    test_sw();
    test_mult();
    test_back_to_back();
    test_cnt_wrap();
    test_reset_mid_mem();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
